// File: rtl/dm_arbiter_if.sv
// Requester-side and memory-side signals of the data-memory arbiter.
// slave = arbiter view, master = requesters + datamem view.
interface dm_arbiter_if #(
    parameter int unsigned AW = 24,
    parameter int unsigned DW = 16
) ();
    logic          cpu_req;
    logic          cpu_we;
    logic [AW-1:0] cpu_addr;
    logic [DW-1:0] cpu_wdata;
    logic [DW-1:0] cpu_rdata;
    logic          cpu_done;
    logic          cpu_stall;
    logic          dbg_req;
    logic          dbg_we;
    logic [AW-1:0] dbg_addr;
    logic [DW-1:0] dbg_wdata;
    logic [DW-1:0] dbg_rdata;
    logic          dbg_done;
    logic [1:0]    dm_en;
    logic [AW-1:0] dm_addr;
    logic [DW-1:0] dm_wdata;
    logic [DW-1:0] dm_rdata;
    logic [1:0]    owner;

    modport slave (
        input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
        input  dbg_req, dbg_we, dbg_addr, dbg_wdata,
        input  dm_rdata,
        output cpu_rdata, cpu_done, cpu_stall,
        output dbg_rdata, dbg_done,
        output dm_en, dm_addr, dm_wdata, owner
    );

    modport master (
        output cpu_req, cpu_we, cpu_addr, cpu_wdata,
        output dbg_req, dbg_we, dbg_addr, dbg_wdata,
        output dm_rdata,
        input  cpu_rdata, cpu_done, cpu_stall,
        input  dbg_rdata, dbg_done,
        input  dm_en, dm_addr, dm_wdata, owner
    );
endinterface

// File: rtl/dm_arbiter.sv
// Round-robin arbiter sharing the single-port data memory between the CPU
// load/store path and the debug/loader port, LAT memory cycles per access.
module dm_arbiter #(
    parameter int unsigned AW  = 24,
    parameter int unsigned DW  = 16,
    parameter int unsigned LAT = 1
) (
    input  logic        clk,
    input  logic        clear,
    dm_arbiter_if.slave bus
);
    localparam int unsigned   CW       = 4;
    localparam logic [CW-1:0] CNT_LOAD = CW'(LAT - 1);
    localparam logic [1:0]    EN_IDLE  = 2'b00;
    localparam logic [1:0]    EN_READ  = 2'b01;
    localparam logic [1:0]    EN_WRITE = 2'b10;

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_t;
    typedef enum logic [1:0] {OWN_NONE = 2'b00, OWN_CPU = 2'b01, OWN_DBG = 2'b10} owner_t;

    state_t        state_q, state_d;
    owner_t        owner_q, owner_d;
    owner_t        last_q, last_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    en_q, en_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [DW-1:0] cpu_rdata_q, cpu_rdata_d;
    logic [DW-1:0] dbg_rdata_q, dbg_rdata_d;
    logic          cpu_done_q, cpu_done_d;
    logic          dbg_done_q, dbg_done_d;
    logic          grant_cpu_c;

    // CPU wins when alone or on a tie after a debug access.
    assign grant_cpu_c = bus.cpu_req && (!bus.dbg_req || (last_q == OWN_DBG));

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        last_d      = last_q;
        cnt_d       = cnt_q;
        en_d        = en_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        cpu_rdata_d = cpu_rdata_q;
        dbg_rdata_d = dbg_rdata_q;
        cpu_done_d  = 1'b0;
        dbg_done_d  = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                if (grant_cpu_c) begin
                    owner_d = OWN_CPU;
                    en_d    = bus.cpu_we ? EN_WRITE : EN_READ;
                    addr_d  = bus.cpu_addr;
                    wdata_d = bus.cpu_wdata;
                end else if (bus.dbg_req) begin
                    owner_d = OWN_DBG;
                    en_d    = bus.dbg_we ? EN_WRITE : EN_READ;
                    addr_d  = bus.dbg_addr;
                    wdata_d = bus.dbg_wdata;
                end
                if (bus.cpu_req || bus.dbg_req) begin
                    state_d = S_ACCESS;
                    cnt_d   = CNT_LOAD;
                end
            end
            S_ACCESS: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CW'(1);
                end else begin
                    // Last memory cycle: dm_rdata is valid now.
                    if (en_q == EN_READ) begin
                        if (owner_q == OWN_CPU) cpu_rdata_d = bus.dm_rdata;
                        else                    dbg_rdata_d = bus.dm_rdata;
                    end
                    cpu_done_d = (owner_q == OWN_CPU);
                    dbg_done_d = (owner_q == OWN_DBG);
                    last_d     = owner_q;
                    en_d       = EN_IDLE;
                    addr_d     = '0;
                    wdata_d    = '0;
                    state_d    = S_DONE;
                end
            end
            S_DONE: begin
                owner_d = OWN_NONE;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge clear) begin
        if (!clear) begin
            state_q     <= S_IDLE;
            owner_q     <= OWN_NONE;
            last_q      <= OWN_DBG;
            cnt_q       <= '0;
            en_q        <= EN_IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            cpu_rdata_q <= '0;
            dbg_rdata_q <= '0;
            cpu_done_q  <= 1'b0;
            dbg_done_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            last_q      <= last_d;
            cnt_q       <= cnt_d;
            en_q        <= en_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            cpu_rdata_q <= cpu_rdata_d;
            dbg_rdata_q <= dbg_rdata_d;
            cpu_done_q  <= cpu_done_d;
            dbg_done_q  <= dbg_done_d;
        end
    end

    assign bus.dm_en     = en_q;
    assign bus.dm_addr   = addr_q;
    assign bus.dm_wdata  = wdata_q;
    assign bus.owner     = owner_q;
    assign bus.cpu_rdata = cpu_rdata_q;
    assign bus.dbg_rdata = dbg_rdata_q;
    assign bus.cpu_done  = cpu_done_q;
    assign bus.dbg_done  = dbg_done_q;
    assign bus.cpu_stall = bus.cpu_req & ~cpu_done_q;
endmodule

// File: tb/tb_dm_arbiter.sv
// Self-checking bench for dm_arbiter: directed vector table, LAT=3 corner
// sequences, mid-access reset, and randomized rounds against a transaction model.
module tb_dm_arbiter;
    localparam int unsigned AW = 24;
    localparam int unsigned DW = 16;

    logic clk = 1'b0;
    logic clear;
    always #5 clk = ~clk;

    dm_arbiter_if #(.AW(AW), .DW(DW)) ifc1 ();
    dm_arbiter_if #(.AW(AW), .DW(DW)) ifc3 ();

    dm_arbiter #(.AW(AW), .DW(DW), .LAT(1)) u_dut1 (.clk(clk), .clear(clear), .bus(ifc1.slave));
    dm_arbiter #(.AW(AW), .DW(DW), .LAT(3)) u_dut3 (.clk(clk), .clear(clear), .bus(ifc3.slave));

    // Memory models: a real RAM behind the LAT=1 instance, fixed data behind LAT=3.
    logic [DW-1:0] mem1 [256];
    always @(posedge clk) if (ifc1.dm_en == 2'b10) mem1[ifc1.dm_addr[7:0]] <= ifc1.dm_wdata;
    assign ifc1.dm_rdata = mem1[ifc1.dm_addr[7:0]];
    assign ifc3.dm_rdata = (ifc3.dm_addr == 24'h0000FF) ? 16'h1234 : 16'h5A5A;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        ifc1.cpu_req = 1'b0; ifc1.cpu_we = 1'b0; ifc1.cpu_addr = '0; ifc1.cpu_wdata = '0;
        ifc1.dbg_req = 1'b0; ifc1.dbg_we = 1'b0; ifc1.dbg_addr = '0; ifc1.dbg_wdata = '0;
        ifc3.cpu_req = 1'b0; ifc3.cpu_we = 1'b0; ifc3.cpu_addr = '0; ifc3.cpu_wdata = '0;
        ifc3.dbg_req = 1'b0; ifc3.dbg_we = 1'b0; ifc3.dbg_addr = '0; ifc3.dbg_wdata = '0;
    endtask

    typedef struct {
        logic        c, d, cwe, dwe;
        logic [23:0] caddr, daddr;
        logic [15:0] cwd, dwd;
        logic [1:0]  own, en;
        logic [23:0] addr;
        logic [15:0] wd;
        logic        rd_chk;
        logic [15:0] rd;
    } vec_t;
    vec_t vt [10];

    // One access on the LAT=1 instance, applied at a negedge while it is idle.
    task automatic run_vec(input int i, input vec_t v);
        string t;
        int    acc;
        t = $sformatf("vec%0d", i);
        ifc1.cpu_req = v.c; ifc1.cpu_we = v.cwe; ifc1.cpu_addr = v.caddr; ifc1.cpu_wdata = v.cwd;
        ifc1.dbg_req = v.d; ifc1.dbg_we = v.dwe; ifc1.dbg_addr = v.daddr; ifc1.dbg_wdata = v.dwd;
        @(negedge clk);
        chk({t, "_owner"}, 32'(ifc1.owner), 32'(v.own));
        chk({t, "_en"}, 32'(ifc1.dm_en), 32'(v.en));
        chk({t, "_addr"}, 32'(ifc1.dm_addr), 32'(v.addr));
        chk({t, "_wdata"}, 32'(ifc1.dm_wdata), 32'(v.wd));
        chk({t, "_stall_acc"}, 32'(ifc1.cpu_stall), 32'(v.c));
        acc = 0;
        while (ifc1.dm_en != 2'b00 && acc < 20) begin
            acc++;
            @(negedge clk);
        end
        chk({t, "_acc_cycles"}, 32'(acc), 32'(1));
        chk({t, "_cpu_done"}, 32'(ifc1.cpu_done), 32'(v.own == 2'b01));
        chk({t, "_dbg_done"}, 32'(ifc1.dbg_done), 32'(v.own == 2'b10));
        chk({t, "_stall_done"}, 32'(ifc1.cpu_stall), 32'(v.c & (v.own != 2'b01)));
        if (v.rd_chk)
            chk({t, "_rdata"}, 32'((v.own == 2'b01) ? ifc1.cpu_rdata : ifc1.dbg_rdata), 32'(v.rd));
        if (v.own == 2'b01) ifc1.cpu_req = 1'b0;
        else                ifc1.dbg_req = 1'b0;
        @(negedge clk);
        chk({t, "_owner_idle"}, 32'(ifc1.owner), 32'(0));
        chk({t, "_en_idle"}, 32'(ifc1.dm_en), 32'(0));
    endtask

    // Observe 8 cycles of the LAT=3 instance after a request was applied.
    task automatic measure3(input bit chg, input logic [23:0] exp_addr,
                            output int n_acc, output int cpu_d, output int dbg_d,
                            output int done_at, output int addr_bad, output logic [1:0] en_seen);
        n_acc = 0; cpu_d = 0; dbg_d = 0; done_at = 0; addr_bad = 0; en_seen = 2'b00;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (ifc3.dm_en != 2'b00) begin
                n_acc++;
                en_seen = ifc3.dm_en;
                if (ifc3.dm_addr != exp_addr) addr_bad++;
            end
            if (ifc3.cpu_done) begin cpu_d++; done_at = k; ifc3.cpu_req = 1'b0; end
            if (ifc3.dbg_done) begin dbg_d++; done_at = k; ifc3.dbg_req = 1'b0; end
            if (chg && k == 1) begin
                ifc3.cpu_addr = 24'h000020; ifc3.cpu_req = 1'b0;
                ifc3.cpu_we = 1'b0; ifc3.cpu_wdata = 16'h0000;
            end
        end
    endtask

    // Transaction-level reference: arbitration order, memory contents, done timing.
    typedef struct { bit dbg; bit rd; logic [15:0] data; int at; } exp_t;
    logic [15:0] ref_mem [16];
    bit          ref_last_dbg;

    task automatic rnd_round(input bit c, input bit d, input bit cwe, input bit dwe,
                             input logic [3:0] ca, input logic [3:0] da,
                             input logic [15:0] cwd, input logic [15:0] dwd);
        exp_t        q[$];
        exp_t        e;
        bit          first_dbg, who, we_x;
        logic [3:0]  a;
        int          n;
        first_dbg = (c && d) ? !ref_last_dbg : d;
        n = (c && d) ? 2 : 1;
        for (int s = 0; s < n; s++) begin
            who    = (s == 0) ? first_dbg : !first_dbg;
            we_x   = who ? dwe : cwe;
            a      = who ? da : ca;
            e.dbg  = who;
            e.rd   = !we_x;
            e.data = ref_mem[a];
            e.at   = 2 + 3 * s;
            if (we_x) ref_mem[a] = who ? dwd : cwd;
            ref_last_dbg = who;
            q.push_back(e);
        end
        ifc1.cpu_req = c; ifc1.cpu_we = cwe; ifc1.cpu_addr = {16'h0, 4'h4, ca}; ifc1.cpu_wdata = cwd;
        ifc1.dbg_req = d; ifc1.dbg_we = dwe; ifc1.dbg_addr = {16'h0, 4'h4, da}; ifc1.dbg_wdata = dwd;
        for (int k = 1; k <= 12 && q.size() > 0; k++) begin
            @(negedge clk);
            if (ifc1.cpu_done || ifc1.dbg_done) begin
                e = q.pop_front();
                chk("rnd_src", 32'({ifc1.dbg_done, ifc1.cpu_done}), 32'(e.dbg ? 2'b10 : 2'b01));
                chk("rnd_cycle", 32'(k), 32'(e.at));
                if (e.rd) chk("rnd_rdata", 32'(e.dbg ? ifc1.dbg_rdata : ifc1.cpu_rdata), 32'(e.data));
                if (e.dbg) ifc1.dbg_req = 1'b0;
                else       ifc1.cpu_req = 1'b0;
            end
        end
        chk("rnd_pending", 32'(q.size()), 32'(0));
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n_acc, cpu_d, dbg_d, done_at, addr_bad;
        logic [1:0]  en_seen;
        logic [1:0]  exp_own;
        int          seen, cyc, last_cyc, k;

        vt[0] = '{1'b1, 1'b0, 1'b1, 1'b0, 24'h10, 24'h00, 16'hBEEF, 16'h0000, 2'b01, 2'b10, 24'h10, 16'hBEEF, 1'b0, 16'h0000};
        vt[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 24'h10, 24'h00, 16'h0000, 16'h0000, 2'b01, 2'b01, 24'h10, 16'h0000, 1'b1, 16'hBEEF};
        vt[2] = '{1'b1, 1'b1, 1'b0, 1'b1, 24'h10, 24'h11, 16'h0000, 16'h1357, 2'b10, 2'b10, 24'h11, 16'h1357, 1'b0, 16'h0000};
        vt[3] = '{1'b1, 1'b0, 1'b0, 1'b1, 24'h10, 24'h11, 16'h0000, 16'h1357, 2'b01, 2'b01, 24'h10, 16'h0000, 1'b1, 16'hBEEF};
        vt[4] = '{1'b0, 1'b1, 1'b0, 1'b0, 24'h10, 24'h11, 16'h0000, 16'h0000, 2'b10, 2'b01, 24'h11, 16'h0000, 1'b1, 16'h1357};
        vt[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 24'h12, 24'h12, 16'hAAAA, 16'h0000, 2'b01, 2'b10, 24'h12, 16'hAAAA, 1'b0, 16'h0000};
        vt[6] = '{1'b0, 1'b1, 1'b1, 1'b0, 24'h12, 24'h12, 16'hAAAA, 16'h0000, 2'b10, 2'b01, 24'h12, 16'h0000, 1'b1, 16'hAAAA};
        vt[7] = '{1'b1, 1'b1, 1'b0, 1'b1, 24'h11, 24'h10, 16'h0000, 16'h5555, 2'b01, 2'b01, 24'h11, 16'h0000, 1'b1, 16'h1357};
        vt[8] = '{1'b0, 1'b1, 1'b0, 1'b1, 24'h11, 24'h10, 16'h0000, 16'h5555, 2'b10, 2'b10, 24'h10, 16'h5555, 1'b0, 16'h0000};
        vt[9] = '{1'b1, 1'b0, 1'b0, 1'b0, 24'h10, 24'h00, 16'h0000, 16'h0000, 2'b01, 2'b01, 24'h10, 16'h0000, 1'b1, 16'h5555};

        clear = 1'b0;
        idle_inputs();
        repeat (3) @(negedge clk);
        chk("rst_en", 32'(ifc1.dm_en), 32'(0));
        chk("rst_owner", 32'(ifc1.owner), 32'(0));
        chk("rst_addr", 32'(ifc1.dm_addr), 32'(0));
        chk("rst_wdata", 32'(ifc1.dm_wdata), 32'(0));
        chk("rst_dones", 32'({ifc1.dbg_done, ifc1.cpu_done}), 32'(0));
        chk("rst_rdata", 32'({ifc1.dbg_rdata, ifc1.cpu_rdata}), 32'(0));
        chk("rst_stall", 32'(ifc1.cpu_stall), 32'(0));
        chk("rst_en3", 32'({ifc3.dm_en, ifc3.owner}), 32'(0));
        clear = 1'b1;
        @(negedge clk);

        // Both requesting continuously from reset: grants alternate, CPU first.
        ifc1.cpu_req = 1'b1; ifc1.cpu_addr = 24'h40;
        ifc1.dbg_req = 1'b1; ifc1.dbg_addr = 24'h41;
        seen = 0; cyc = 0; last_cyc = 0; exp_own = 2'b01;
        while (seen < 6 && cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (ifc1.cpu_done || ifc1.dbg_done) begin
                chk("alt_owner", 32'(ifc1.owner), 32'(exp_own));
                chk("alt_done_src", 32'({ifc1.dbg_done, ifc1.cpu_done}), 32'(exp_own));
                chk("alt_spacing", 32'(cyc - last_cyc), 32'((seen == 0) ? 2 : 3));
                last_cyc = cyc;
                seen++;
                exp_own = (exp_own == 2'b01) ? 2'b10 : 2'b01;
                if (seen == 6) begin ifc1.cpu_req = 1'b0; ifc1.dbg_req = 1'b0; end
            end
        end
        chk("alt_count", 32'(seen), 32'(6));
        @(negedge clk);

        for (int i = 0; i < 10; i++) run_vec(i, vt[i]);

        // LAT=3: CPU read, debug read, then CPU write with inputs changed mid-access.
        ifc3.cpu_req = 1'b1; ifc3.cpu_we = 1'b0; ifc3.cpu_addr = 24'h000000;
        measure3(1'b0, 24'h000000, n_acc, cpu_d, dbg_d, done_at, addr_bad, en_seen);
        chk("l3_cpu_acc", 32'(n_acc), 32'(3));
        chk("l3_cpu_en", 32'(en_seen), 32'(2'b01));
        chk("l3_cpu_done_at", 32'(done_at), 32'(4));
        chk("l3_cpu_dones", 32'({cpu_d[7:0], dbg_d[7:0]}), 32'(16'h0100));
        chk("l3_cpu_rdata", 32'(ifc3.cpu_rdata), 32'(16'h5A5A));

        ifc3.dbg_req = 1'b1; ifc3.dbg_we = 1'b0; ifc3.dbg_addr = 24'h0000FF;
        measure3(1'b0, 24'h0000FF, n_acc, cpu_d, dbg_d, done_at, addr_bad, en_seen);
        chk("l3_dbg_acc", 32'(n_acc), 32'(3));
        chk("l3_dbg_en", 32'(en_seen), 32'(2'b01));
        chk("l3_dbg_done_at", 32'(done_at), 32'(4));
        chk("l3_dbg_dones", 32'({cpu_d[7:0], dbg_d[7:0]}), 32'(16'h0001));
        chk("l3_dbg_addr_bad", 32'(addr_bad), 32'(0));
        chk("l3_dbg_rdata", 32'(ifc3.dbg_rdata), 32'(16'h1234));
        chk("l3_cpu_rdata_kept", 32'(ifc3.cpu_rdata), 32'(16'h5A5A));

        ifc3.cpu_req = 1'b1; ifc3.cpu_we = 1'b1; ifc3.cpu_addr = 24'h000030; ifc3.cpu_wdata = 16'h7777;
        measure3(1'b1, 24'h000030, n_acc, cpu_d, dbg_d, done_at, addr_bad, en_seen);
        chk("chg_acc", 32'(n_acc), 32'(3));
        chk("chg_en", 32'(en_seen), 32'(2'b10));
        chk("chg_addr_bad", 32'(addr_bad), 32'(0));
        chk("chg_dones", 32'({cpu_d[7:0], dbg_d[7:0]}), 32'(16'h0100));
        chk("chg_done_at", 32'(done_at), 32'(4));
        chk("chg_rdata_kept", 32'(ifc3.cpu_rdata), 32'(16'h5A5A));

        // Reset in the middle of an access.
        ifc1.cpu_req = 1'b1; ifc1.cpu_we = 1'b0; ifc1.cpu_addr = 24'h10;
        @(negedge clk);
        chk("rst_pre_en", 32'(ifc1.dm_en), 32'(2'b01));
        clear = 1'b0;
        #1;
        chk("rst_mid_en", 32'(ifc1.dm_en), 32'(0));
        chk("rst_mid_owner", 32'(ifc1.owner), 32'(0));
        chk("rst_mid_rdata", 32'(ifc1.cpu_rdata), 32'(0));
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("rst_no_done", 32'(ifc1.cpu_done), 32'(0));
        end
        ifc1.dbg_req = 1'b1; ifc1.dbg_we = 1'b0; ifc1.dbg_addr = 24'h11;
        clear = 1'b1;
        @(negedge clk);
        chk("rst_tie_owner", 32'(ifc1.owner), 32'(2'b01));
        k = 0;
        while (!ifc1.cpu_done && k < 10) begin k++; @(negedge clk); end
        chk("rst_tie_done", 32'(ifc1.cpu_done), 32'(1));
        ifc1.cpu_req = 1'b0; ifc1.dbg_req = 1'b0;
        @(negedge clk);

        // Randomized rounds from a fresh reset (last owner = debug).
        clear = 1'b0;
        @(negedge clk);
        clear = 1'b1;
        @(negedge clk);
        ref_last_dbg = 1'b1;
        for (int i = 0; i < 16; i++)
            rnd_round(i[0] == 1'b0, i[0] == 1'b1, 1'b1, 1'b1, 4'(i), 4'(i), 16'($urandom), 16'($urandom));
        for (int i = 0; i < 40; i++) begin
            bit c, d;
            c = 1'($urandom_range(0, 1));
            d = 1'($urandom_range(0, 1));
            if (!c && !d) c = 1'b1;
            rnd_round(c, d, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                      4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
                      16'($urandom), 16'($urandom));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
